// File: rtl/ysyx_25040109_lsu.sv
// Load/store unit: one CPU request at a time, carried out as an AXI4-Lite master transaction.
// Define YSYX_25040109_LSU_MISALIGN_CHK_EN to answer misaligned half/word accesses with an error and no bus cycle.
module ysyx_25040109_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        dmem_arvalid_o,
  output logic [31:0] dmem_araddr_o,
  input  logic        dmem_arready_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic [1:0]  dmem_rresp_i,
  output logic        dmem_rready_o,
  output logic        dmem_awvalid_o,
  output logic [31:0] dmem_awaddr_o,
  input  logic        dmem_awready_i,
  output logic        dmem_wvalid_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_wready_i,
  input  logic        dmem_bvalid_i,
  input  logic [1:0]  dmem_bresp_i,
  output logic        dmem_bready_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4,
    S_RSP  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        req_fire_s, aw_fire_s, w_fire_s, misalign_s;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    res = {{24{~uns & sh[7]}}, sh[7:0]};
      2'd1:    res = {{16{~uns & sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

`ifdef YSYX_25040109_LSU_MISALIGN_CHK_EN
  always_comb begin
    misalign_s = 1'b0;
    case (req_size_i)
      2'd0:    misalign_s = 1'b0;
      2'd1:    misalign_s = req_addr_i[0];
      default: misalign_s = (req_addr_i[1:0] != 2'b00);
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  assign req_fire_s = req_valid_i && (state_q == S_IDLE);
  assign aw_fire_s  = (state_q == S_WR) && !aw_done_q && dmem_awready_i;
  assign w_fire_s   = (state_q == S_WR) && !w_done_q && dmem_wready_i;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire_s) begin
          if (misalign_s)     state_d = S_RSP;
          else if (req_wen_i) state_d = S_WR;
          else                state_d = S_AR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR:  state_d = dmem_arready_i ? S_R : S_AR;
      S_R:   state_d = dmem_rvalid_i ? S_RSP : S_R;
      // Each write channel may complete first; B waits for both.
      S_WR:  state_d = ((aw_done_q || aw_fire_s) && (w_done_q || w_fire_s)) ? S_B : S_WR;
      S_B:   state_d = dmem_bvalid_i ? S_RSP : S_B;
      S_RSP: state_d = rsp_ready_i ? S_IDLE : S_RSP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o    = 1'b0;
    dmem_arvalid_o = 1'b0;
    dmem_rready_o  = 1'b0;
    dmem_awvalid_o = 1'b0;
    dmem_wvalid_o  = 1'b0;
    dmem_bready_o  = 1'b0;
    rsp_valid_o    = 1'b0;
    case (state_q)
      S_IDLE: req_ready_o    = 1'b1;
      S_AR:   dmem_arvalid_o = 1'b1;
      S_R:    dmem_rready_o  = 1'b1;
      S_WR: begin
        dmem_awvalid_o = !aw_done_q;
        dmem_wvalid_o  = !w_done_q;
      end
      S_B:    dmem_bready_o  = 1'b1;
      S_RSP:  rsp_valid_o    = 1'b1;
      default: req_ready_o   = 1'b0;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_fire_s) begin
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          size_d      = req_size_i;
          unsigned_d  = req_unsigned_i;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          rsp_err_d   = misalign_s;
          rsp_rdata_d = misalign_s ? 32'h0000_0000 : rsp_rdata_q;
        end else begin
          rsp_err_d   = rsp_err_q;
        end
      end
      S_R: begin
        if (dmem_rvalid_i) begin
          rsp_err_d   = (dmem_rresp_i != 2'b00);
          rsp_rdata_d = (dmem_rresp_i != 2'b00) ? 32'h0000_0000
                        : load_extract(dmem_rdata_i, addr_q[1:0], size_q, unsigned_q);
        end else begin
          rsp_err_d   = rsp_err_q;
        end
      end
      S_WR: begin
        aw_done_d = aw_done_q || aw_fire_s;
        w_done_d  = w_done_q || w_fire_s;
      end
      S_B: begin
        if (dmem_bvalid_i) begin
          rsp_err_d   = (dmem_bresp_i != 2'b00);
          rsp_rdata_d = 32'h0000_0000;
        end else begin
          rsp_err_d   = rsp_err_q;
        end
      end
      default: rsp_err_d = rsp_err_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Bus address is the raw byte address; the slave applies lane shifting.
  assign dmem_araddr_o = addr_q;
  assign dmem_awaddr_o = addr_q;
  assign dmem_wdata_o  = wdata_q;
  assign dmem_wstrb_o  = store_strobe(size_q, addr_q[1:0]);
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Randomised bench for ysyx_25040109_lsu: AXI4-Lite slave with random latencies plus a byte-level memory model.
module tb_ysyx_25040109_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [1:0] req_size = 2'd0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [31:0] araddr, rdata = 32'h0;
  logic [1:0] rresp = 2'b00;
  logic awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic [31:0] awaddr, wdata_o;
  logic [3:0] wstrb;
  logic [1:0] bresp = 2'b00;

  ysyx_25040109_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .dmem_arvalid_o(arvalid), .dmem_araddr_o(araddr), .dmem_arready_i(arready),
    .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata), .dmem_rresp_i(rresp), .dmem_rready_o(rready),
    .dmem_awvalid_o(awvalid), .dmem_awaddr_o(awaddr), .dmem_awready_i(awready),
    .dmem_wvalid_o(wvalid), .dmem_wdata_o(wdata_o), .dmem_wstrb_o(wstrb), .dmem_wready_i(wready),
    .dmem_bvalid_i(bvalid), .dmem_bresp_i(bresp), .dmem_bready_o(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // slave memory (written by bus traffic) and reference memory (written by request semantics)
  logic [7:0] smem [64];
  logic [7:0] mmem [64];
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, cyc = 0;
  int max_dly = 3, aw_hold = 0;
  bit b_hold = 0, inject_late = 0;
  logic [31:0] cap_araddr = 32'h0, cap_awaddr = 32'h0, cap_wdata = 32'h0;
  logic [3:0] cap_wstrb = 4'h0;
  int aw_fire_cyc = 0, w_fire_cyc = 0, first_bready_cyc = -1;

  function automatic bit mapped(input logic [31:0] a);
    return (a & 32'hFFFF_FFC0) == 32'h8000_0000;
  endfunction

  function automatic int word_base(input logic [31:0] a);
    return int'(a[5:2]) * 4;
  endfunction

  // AXI4-Lite slave: snapshot at negedge, react just after posedge
  initial begin : slave
    bit rst_s, ar_f, r_f, aw_f, w_f, b_f, br_s;
    logic [31:0] ar_a, aw_a, w_d, sh;
    logic [3:0] w_s;
    int ar_dly, rd_dly, aw_dly, w_dly, b_dly, base;
    bit rd_pend, aw_got, w_got, b_pend;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [3:0] wr_strb;
    logic [1:0] bresp_v;
    ar_dly = -1; aw_dly = -1; w_dly = -1; rd_dly = 0; b_dly = 0;
    rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; bresp_v = 2'b00;
    rd_addr = 32'h0; wr_addr = 32'h0; wr_data = 32'h0; wr_strb = 4'h0;
    forever begin
      @(negedge clk);
      rst_s = rst; br_s = bready;
      ar_f = arvalid && arready; r_f = rvalid && rready; b_f = bvalid && bready;
      aw_f = awvalid && awready; w_f = wvalid && wready;
      ar_a = araddr; aw_a = awaddr; w_d = wdata_o; w_s = wstrb;
      @(posedge clk); #1;
      cyc++;
      if (rst_s) begin
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        ar_dly = -1; aw_dly = -1; w_dly = -1;
      end else begin
        if (ar_f) begin rd_pend = 1; rd_addr = ar_a; rd_dly = $urandom_range(max_dly, 0); ar_cnt++; cap_araddr = ar_a; end
        if (r_f) rd_pend = 0;
        if (aw_f) begin aw_got = 1; wr_addr = aw_a; aw_cnt++; cap_awaddr = aw_a; aw_fire_cyc = cyc; end
        if (w_f) begin w_got = 1; wr_data = w_d; wr_strb = w_s; w_cnt++; cap_wdata = w_d; cap_wstrb = w_s; w_fire_cyc = cyc; end
        if (br_s && first_bready_cyc < 0) first_bready_cyc = cyc;
        if (b_f) b_pend = 0;
        if (aw_got && w_got) begin
          if (mapped(wr_addr)) begin
            sh = wr_data << {wr_addr[1:0], 3'b000};
            base = word_base(wr_addr);
            for (int i = 0; i < 4; i++) if (wr_strb[i]) smem[base + i] = sh[8*i +: 8];
            bresp_v = 2'b00;
          end else begin
            bresp_v = 2'b11;
          end
          b_pend = 1; b_dly = $urandom_range(max_dly, 0); aw_got = 0; w_got = 0;
        end
      end
      if (arvalid && !rd_pend) begin
        if (ar_dly < 0) ar_dly = $urandom_range(max_dly, 0);
        arready = (ar_dly == 0);
        if (ar_dly > 0) ar_dly--;
      end else begin arready = 1'b0; ar_dly = -1; end
      if (inject_late) begin rvalid = 1'b1; rdata = $urandom; rresp = 2'b00; end
      else if (rd_pend && rd_dly == 0) begin
        base = word_base(rd_addr);
        rvalid = 1'b1;
        rdata = {smem[base + 3], smem[base + 2], smem[base + 1], smem[base]};
        rresp = mapped(rd_addr) ? 2'b00 : 2'b10;
      end else begin
        rvalid = 1'b0; rdata = $urandom; rresp = 2'b00;
        if (rd_pend) rd_dly--;
      end
      if (awvalid && !aw_got) begin
        if (aw_hold > 0) begin awready = 1'b0; aw_hold--; end
        else begin
          if (aw_dly < 0) aw_dly = $urandom_range(max_dly, 0);
          awready = (aw_dly == 0);
          if (aw_dly > 0) aw_dly--;
        end
      end else begin awready = 1'b0; aw_dly = -1; end
      if (wvalid && !w_got) begin
        if (w_dly < 0) w_dly = $urandom_range(max_dly, 0);
        wready = (w_dly == 0);
        if (w_dly > 0) w_dly--;
      end else begin wready = 1'b0; w_dly = -1; end
      if (inject_late) begin bvalid = 1'b1; bresp = 2'b00; end
      else if (b_pend && b_hold) begin bvalid = 1'b0; b_dly = 0; end
      else if (b_pend && b_dly == 0) begin bvalid = 1'b1; bresp = bresp_v; end
      else begin
        bvalid = 1'b0; bresp = 2'b00;
        if (b_pend) b_dly--;
      end
    end
  end

  task automatic set_word(input int idx, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin smem[idx + i] = w[8*i +: 8]; mmem[idx + i] = w[8*i +: 8]; end
  endtask

  // Reference model: apply the request to mmem / compute expected response
  task automatic model(input bit wen, input logic [31:0] a, input logic [1:0] sz, input bit uns,
                       input logic [31:0] wd, output logic [31:0] exp_rd, output bit exp_err,
                       output bit mis, output logic [3:0] exp_strb);
    int n, off, base;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    base = word_base(a);
    mis = 0;
`ifdef YSYX_25040109_LSU_MISALIGN_CHK_EN
    mis = (n > 1) && (off % n != 0);
`endif
    exp_strb = 4'h0;
    for (int k = 0; k < n; k++) if (off + k < 4) exp_strb[off + k] = 1'b1;
    exp_rd = 32'h0; exp_err = 0; v = 32'h0;
    if (mis || !mapped(a)) exp_err = 1;
    else if (wen) begin
      for (int k = 0; k < n; k++) if (off + k < 4) mmem[base + off + k] = wd[8*k +: 8];
    end else begin
      for (int k = 0; k < n; k++) if (off + k < 4) v[8*k +: 8] = mmem[base + off + k];
      if (!uns && v[8*n - 1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
      exp_rd = v;
    end
  endtask

  task automatic do_req(input string tag, input bit wen, input logic [31:0] a, input logic [1:0] sz,
                        input bit uns, input logic [31:0] wd, input int hold,
                        output logic [31:0] got_rd, output logic got_err);
    logic [31:0] exp_rd;
    logic [3:0] exp_strb;
    bit exp_err, mis;
    int ar0, aw0, w0, waited;
    model(wen, a, sz, uns, wd, exp_rd, exp_err, mis, exp_strb);
    ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_size = sz; req_unsigned = uns; req_wdata = wd;
    @(negedge clk);
    chk_eq({tag, "/req_ready"}, req_ready, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom); req_unsigned = 1'($urandom);
    waited = 0;
    do begin @(negedge clk); waited++; end while (!rsp_valid && waited < 300);
    chk_eq({tag, "/rsp_valid"}, rsp_valid, 32'd1);
    if (mis) chk_eq({tag, "/mis_latency"}, waited, 32'd1);
    got_rd = rsp_rdata; got_err = rsp_err;
    chk_eq({tag, "/rdata"}, rsp_rdata, exp_rd);
    chk_eq({tag, "/err"}, rsp_err, exp_err);
    chk_eq({tag, "/busy"}, req_ready, 32'd0);
    chk_eq({tag, "/ar_cnt"}, ar_cnt - ar0, (!wen && !mis) ? 32'd1 : 32'd0);
    chk_eq({tag, "/aw_cnt"}, aw_cnt - aw0, (wen && !mis) ? 32'd1 : 32'd0);
    chk_eq({tag, "/w_cnt"}, w_cnt - w0, (wen && !mis) ? 32'd1 : 32'd0);
    if (!wen && !mis) chk_eq({tag, "/araddr"}, cap_araddr, a);
    if (wen && !mis) begin
      chk_eq({tag, "/awaddr"}, cap_awaddr, a);
      chk_eq({tag, "/wdata"}, cap_wdata, wd);
      chk_eq({tag, "/wstrb"}, cap_wstrb, exp_strb);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk_eq({tag, "/hold_valid"}, rsp_valid, 32'd1);
      chk_eq({tag, "/hold_rdata"}, rsp_rdata, got_rd);
      chk_eq({tag, "/hold_err"}, rsp_err, got_err);
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    @(negedge clk);
    chk_eq({tag, "/done_valid"}, rsp_valid, 32'd0);
    chk_eq({tag, "/done_ready"}, req_ready, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_eq({tag, "/req_ready"}, req_ready, 32'd1);
    chk_eq({tag, "/valids"}, {arvalid, awvalid, wvalid, rready, bready, rsp_valid}, 32'd0);
    chk_eq({tag, "/rsp_err"}, rsp_err, 32'd0);
    chk_eq({tag, "/rsp_rdata"}, rsp_rdata, 32'd0);
  endtask

  initial begin : stim
    logic [31:0] rd, a, wd;
    logic er;
    logic [31:0] erd;
    logic [3:0] est;
    bit eer, mis;
    int waited;
    for (int i = 0; i < 64; i++) begin smem[i] = 8'($urandom); mmem[i] = smem[i]; end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1; rst = 1'b0;

    max_dly = 31;
    set_word(16, 32'hDEAD_BEEF);
    do_req("ldw", 1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'h0, 0, rd, er);
    chk_eq("ldw/const", rd, 32'hDEAD_BEEF);
    max_dly = 3;
    set_word(16, 32'h85FF_0000);
    do_req("lbs", 1'b0, 32'h8000_0013, 2'd0, 1'b0, 32'h0, 0, rd, er);
    chk_eq("lbs/const", rd, 32'hFFFF_FF85);
    do_req("lbu", 1'b0, 32'h8000_0013, 2'd0, 1'b1, 32'h0, 0, rd, er);
    chk_eq("lbu/const", rd, 32'h0000_0085);

    max_dly = 0; aw_hold = 5; first_bready_cyc = -1;
    do_req("sh", 1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_ABCD, 0, rd, er);
    chk_eq("sh/wstrb_const", cap_wstrb, 32'hC);
    chk_eq("sh/err_const", er, 32'd0);
    chk_eq("sh/w_first", w_fire_cyc < aw_fire_cyc, 32'd1);
    chk_eq("sh/b_after_aw", first_bready_cyc > aw_fire_cyc, 32'd1);
    max_dly = 3;
    do_req("lhu_back", 1'b0, 32'h8000_0002, 2'd1, 1'b1, 32'h0, 0, rd, er);
    chk_eq("lhu_back/const", rd, 32'h0000_ABCD);

    do_req("unmapped", 1'b0, 32'h0000_1000, 2'd2, 1'b0, 32'h0, 0, rd, er);
    chk_eq("unmapped/err_const", er, 32'd1);
    do_req("misw", 1'b0, 32'h8000_0001, 2'd2, 1'b1, 32'h0, 0, rd, er);

    do_req("hold10", 1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'h0, 10, rd, er);

    // reset while in B with bvalid asserted
    wd = $urandom;
    model(1'b1, 32'h8000_0020, 2'd2, 1'b0, wd, erd, eer, mis, est);
    b_hold = 1;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020; req_size = 2'd2; req_wdata = wd;
    @(posedge clk); #1; req_valid = 1'b0;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!bready && waited < 100);
    chk_eq("rstB/in_b", bready, 32'd1);
    b_hold = 0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk_eq("rstB/pending", {bvalid, bready}, 32'd3);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("rstB/after");

    inject_late = 1;
    repeat (3) begin
      @(negedge clk);
      chk_eq("late/ignored", {req_ready, rsp_valid, rready, bready}, 32'h8);
    end
    inject_late = 0;
    @(negedge clk);
    @(posedge clk); #1;

    for (int t = 0; t < 80; t++) begin
      max_dly = $urandom_range(4, 0);
      if ($urandom_range(7, 0) == 0) a = 32'h1000_0000 | 32'($urandom_range(255, 0));
      else a = 32'h8000_0000 + 32'($urandom_range(63, 0));
      do_req($sformatf("rnd%0d", t), 1'($urandom), a, 2'($urandom_range(3, 0)), 1'($urandom),
             $urandom, $urandom_range(2, 0), rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
